mips32_result_tracer: RTL and testbench

- Parametrised trace buffer that captures the single-cycle core's result bus into a FIFO, stamping each entry with a free-running cycle count.
- Replaces per-cycle printing of the result word with a buffered, drainable trace that also supports a capture-on-change mode.
- Sits beside mips32_single_cycle: result in, ready/valid read port out to the bench or a debug UART.

---
 rtl/mips32_trace_pkg.sv | 16 +
 rtl/mips32_trace_fifo.sv | 68 ++++++
 rtl/mips32_result_tracer.sv | 91 +++++++++
 tb/tb_mips32_result_tracer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_trace_pkg.sv
// Shared types and constants for the mips32 result tracer.
// Holds capture modes, default widths and the trace entry bundle.
package mips32_trace_pkg;

    localparam logic MODE_ALL    = 1'b0;
    localparam logic MODE_CHANGE = 1'b1;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_TS_W   = 16;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_TS_W-1:0]   stamp;
    } trace_entry_t;

endpackage

// File: rtl/mips32_trace_fifo.sv
// Synchronous show-ahead FIFO of W-bit entries, DEPTH deep.
// Ports: flush/push/wdata in; pop in; rdata (head, 0 when empty), count, full, empty out.
module mips32_trace_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is only legal when the head leaves this cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    // Head is masked so stale storage never shows after reset or flush.
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mips32_result_tracer.sv
// Trace buffer for the single-cycle core result bus with cycle stamps.
// Ports: enable/mode/clear/result in; rd_ready in; rd_valid/rd_data/rd_stamp/count/full/empty/overflow out.
module mips32_result_tracer
    import mips32_trace_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 16,
    parameter int TS_W   = DEF_TS_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   mode,
    input  logic                   clear,
    input  logic [DATA_W-1:0]      result,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [DATA_W-1:0]      rd_data,
    output logic [TS_W-1:0]        rd_stamp,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   stamp;
    } entry_t;

    logic [TS_W-1:0]   stamp;
    logic [DATA_W-1:0] last_result;
    logic              last_valid;
    logic              changed;
    logic              capture;
    logic              pop;
    entry_t            wentry;
    entry_t            rentry;

    // First enabled cycle after reset/clear always counts as a change.
    assign changed = !last_valid || (result != last_result);
    assign capture = enable && !clear && ((mode == MODE_ALL) || changed);
    assign pop     = rd_valid && rd_ready && !clear;

    assign wentry.data  = result;
    assign wentry.stamp = stamp;

    assign rd_valid = !empty;
    assign rd_data  = rentry.data;
    assign rd_stamp = rentry.stamp;

    mips32_trace_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clear),
        .push  (capture),
        .wdata (wentry),
        .pop   (pop),
        .rdata (rentry),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stamp       <= '0;
            last_result <= '0;
            last_valid  <= 1'b0;
            overflow    <= 1'b0;
        end else if (clear) begin
            stamp      <= '0;
            last_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (enable) begin
                stamp       <= stamp + TS_W'(1);
                last_result <= result;
                last_valid  <= 1'b1;
            end
            // Dropped capture: full with no pop to make room.
            if (capture && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips32_result_tracer.sv
// Directed bench for mips32_result_tracer.
// Main instance uses defaults; a second instance with TS_W=4 covers stamp wrap.
module tb_mips32_result_tracer;
    import mips32_trace_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        enable, mode, clear, rd_ready;
    logic [31:0] result;
    logic        rd_valid, full, empty, overflow;
    logic [31:0] rd_data;
    logic [15:0] rd_stamp;
    logic [4:0]  count;

    logic        w_enable, w_rd_ready;
    logic [31:0] w_result;
    logic        w_rd_valid, w_full, w_empty, w_overflow;
    logic [31:0] w_rd_data;
    logic [3:0]  w_rd_stamp;
    logic [4:0]  w_count;

    int n_cmp = 0;
    int n_err = 0;

    mips32_result_tracer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .mode     (mode),
        .clear    (clear),
        .result   (result),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_stamp (rd_stamp),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    mips32_result_tracer #(.TS_W(4)) dut_w (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (w_enable),
        .mode     (MODE_ALL),
        .clear    (1'b0),
        .result   (w_result),
        .rd_ready (w_rd_ready),
        .rd_valid (w_rd_valid),
        .rd_data  (w_rd_data),
        .rd_stamp (w_rd_stamp),
        .count    (w_count),
        .full     (w_full),
        .empty    (w_empty),
        .overflow (w_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    trace_entry_t exp2 [2];

    initial begin
        rst_n = 1'b0;
        enable = 0; mode = MODE_ALL; clear = 0; rd_ready = 0; result = '0;
        w_enable = 0; w_rd_ready = 0; w_result = '0;
        #12;
        chk("rst_valid", rd_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_stamp", rd_stamp, 0);
        rst_n = 1'b1;

        // 1: capture every cycle, then drain
        enable = 1; result = 32'hA;
        tick();
        chk("t1_lat_valid", rd_valid, 1);
        chk("t1_lat_count", count, 1);
        result = 32'hB; tick();
        result = 32'hC; tick();
        enable = 0;
        chk("t1_count", count, 3);
        chk("t1_head_data", rd_data, 32'hA);
        chk("t1_head_stamp", rd_stamp, 0);
        rd_ready = 1;
        for (int i = 0; i < 3; i++) begin
            chk("t1_drain_data", rd_data, 32'hA + i);
            chk("t1_drain_stamp", rd_stamp, i);
            tick();
        end
        rd_ready = 0;
        chk("t1_empty", empty, 1);

        // 2: capture on change
        do_clear();
        mode = MODE_CHANGE; enable = 1; result = 32'h5;
        repeat (4) tick();
        result = 32'h6; tick();
        enable = 0;
        chk("t2_count", count, 2);
        exp2[0] = '{data: 32'h5, stamp: 16'd0};
        exp2[1] = '{data: 32'h6, stamp: 16'd4};
        rd_ready = 1;
        for (int i = 0; i < 2; i++) begin
            chk("t2_data", rd_data, exp2[i].data);
            chk("t2_stamp", rd_stamp, exp2[i].stamp);
            tick();
        end
        rd_ready = 0;
        chk("t2_empty", empty, 1);

        // 3: overflow
        do_clear();
        mode = MODE_ALL; enable = 1;
        for (int i = 0; i < 16; i++) begin
            result = i; tick();
        end
        chk("t3_full", full, 1);
        chk("t3_ovf_pre", overflow, 0);
        for (int i = 16; i < 18; i++) begin
            result = i; tick();
        end
        enable = 0;
        chk("t3_ovf", overflow, 1);
        chk("t3_count", count, 16);
        chk("t3_head_stamp", rd_stamp, 0);
        chk("t3_head_data", rd_data, 0);

        // 4: full with simultaneous push and pop
        do_clear();
        chk("t4_clr_ovf", overflow, 0);
        enable = 1;
        for (int i = 0; i < 16; i++) begin
            result = 100 + i; tick();
        end
        chk("t4_full", full, 1);
        rd_ready = 1;
        for (int i = 0; i < 5; i++) begin
            result = 200 + i;
            chk("t4_pop_stamp", rd_stamp, i);
            tick();
            chk("t4_count", count, 16);
        end
        enable = 0; rd_ready = 0;
        chk("t4_ovf", overflow, 0);
        chk("t4_head_stamp", rd_stamp, 5);

        // 6: clear dominates capture and pop
        do_clear();
        enable = 1; mode = MODE_ALL;
        for (int i = 0; i < 7; i++) begin
            result = 32'h70; tick();
        end
        chk("t6_count7", count, 7);
        rd_ready = 1; clear = 1;
        tick();
        clear = 0; rd_ready = 0; enable = 0;
        chk("t6_count", count, 0);
        chk("t6_valid", rd_valid, 0);
        chk("t6_ovf", overflow, 0);
        mode = MODE_CHANGE; enable = 1; result = 32'h70;
        tick();
        enable = 0;
        chk("t6_first_count", count, 1);
        chk("t6_first_stamp", rd_stamp, 0);
        chk("t6_first_data", rd_data, 32'h70);

        // 5: 4-bit stamp wrap with continuous drain
        w_enable = 1; w_rd_ready = 1;
        for (int i = 0; i < 18; i++) begin
            w_result = i;
            tick();
            chk("t5_valid", w_rd_valid, 1);
            chk("t5_stamp", w_rd_stamp, i % 16);
        end
        w_enable = 0; w_rd_ready = 0;
        chk("t5_ovf", w_overflow, 0);

        // asynchronous reset mid-operation
        do_clear();
        mode = MODE_ALL; enable = 1; result = 32'h9;
        repeat (3) tick();
        enable = 0;
        chk("ar_count_pre", count, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_count", count, 0);
        chk("ar_valid", rd_valid, 0);
        chk("ar_data", rd_data, 0);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
